mem_stage_ctrl: RTL and testbench

Memory-stage access controller between the EX/MEM pipeline register and the data memory (`DataMem`). It decodes memory operations (load, store, push, pop, 32-bit call/return), owns the stack pointer, and sequences one or two 16-bit accesses on the data memory's MAR/MDR/mem/rw port. It also stalls upstream while busy and returns read data to MEM/WB with a one-cycle valid pulse.

---
 rtl/mem_stage_ctrl_if.sv | 30 +++
 rtl/mem_stage_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Request/response and data-memory port bundle for the memory-stage controller.
// The slave modport is the controller's view; master is the pipeline/memory side.
interface mem_stage_ctrl_if #(
    parameter int WORD_LENGTH   = 16,
    parameter int ADDRESS_SPACE = 12
);
    logic                       req_valid;
    logic [2:0]                 req_op;
    logic [ADDRESS_SPACE-1:0]   req_addr;
    logic [2*WORD_LENGTH-1:0]   req_data;
    logic                       busy;
    logic                       rsp_valid;
    logic [2*WORD_LENGTH-1:0]   rsp_data;
    logic [ADDRESS_SPACE-1:0]   sp;
    logic [ADDRESS_SPACE-1:0]   MAR;
    logic [WORD_LENGTH-1:0]     MDR_in;
    logic                       mem;
    logic                       rw;
    logic [WORD_LENGTH-1:0]     MDR_out;

    modport slave (
        input  req_valid, req_op, req_addr, req_data, MDR_out,
        output busy, rsp_valid, rsp_data, sp, MAR, MDR_in, mem, rw
    );

    modport master (
        output req_valid, req_op, req_addr, req_data, MDR_out,
        input  busy, rsp_valid, rsp_data, sp, MAR, MDR_in, mem, rw
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: decodes load/store/stack/call/return ops,
// owns the stack pointer and sequences one or two data-memory accesses.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; new request may be accepted
// A1    | first data-memory access (the only one for single-word ops)
// A2    | second access of CALL (low word write) or RET (high word read)
module mem_stage_ctrl #(
    parameter int WORD_LENGTH   = 16,
    parameter int ADDRESS_SPACE = 12,
    parameter int SP_RESET      = 2**ADDRESS_SPACE - 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_stage_ctrl_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_A1   = 2'd1;
    localparam logic [1:0] S_A2   = 2'd2;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDD  = 3'd1;
    localparam logic [2:0] OP_STD  = 3'd2;
    localparam logic [2:0] OP_PUSH = 3'd3;
    localparam logic [2:0] OP_POP  = 3'd4;
    localparam logic [2:0] OP_CALL = 3'd5;
    localparam logic [2:0] OP_RET  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    localparam logic [ADDRESS_SPACE-1:0] SP_INIT = ADDRESS_SPACE'(SP_RESET);
    localparam logic [ADDRESS_SPACE-1:0] ONE     = ADDRESS_SPACE'(1);
    localparam logic [ADDRESS_SPACE-1:0] TWO     = ADDRESS_SPACE'(2);

    logic [1:0]                 r_state;
    logic [2:0]                 r_op;
    logic [ADDRESS_SPACE-1:0]   r_addr;
    logic [2*WORD_LENGTH-1:0]   r_data;
    logic [ADDRESS_SPACE-1:0]   r_sp;
    logic [WORD_LENGTH-1:0]     r_ret_lo;
    logic                       r_rsp_valid;
    logic [2*WORD_LENGTH-1:0]   r_rsp_data;

    logic                       w_accept;
    logic                       w_two_word;
    logic                       w_is_read;
    logic                       w_last;
    logic                       w_mem;
    logic                       w_rw;
    logic [ADDRESS_SPACE-1:0]   w_mar;
    logic [WORD_LENGTH-1:0]     w_mdr_in;
    logic [ADDRESS_SPACE-1:0]   w_sp_next;

    assign w_accept   = (r_state == S_IDLE) && bus.req_valid &&
                        (bus.req_op != OP_NOP) && (bus.req_op != OP_RSVD);
    assign w_two_word = (r_op == OP_CALL) || (r_op == OP_RET);
    assign w_is_read  = (r_op == OP_LDD) || (r_op == OP_POP) || (r_op == OP_RET);
    // Closing edge of the op's final access: SP update and response happen here.
    assign w_last     = ((r_state == S_A1) && !w_two_word) || (r_state == S_A2);

    // Drive the data-memory port from state so that mem drops with async reset.
    always_comb begin
        w_mem    = 1'b0;
        w_rw     = 1'b0;
        w_mar    = '0;
        w_mdr_in = '0;
        case (r_state)
            S_A1: begin
                w_mem = 1'b1;
                w_rw  = w_is_read;
                case (r_op)
                    OP_LDD:  w_mar = r_addr;
                    OP_STD: begin
                        w_mar    = r_addr;
                        w_mdr_in = r_data[WORD_LENGTH-1:0];
                    end
                    OP_PUSH: begin
                        w_mar    = r_sp;
                        w_mdr_in = r_data[WORD_LENGTH-1:0];
                    end
                    OP_POP:  w_mar = r_sp + ONE;
                    OP_CALL: begin
                        w_mar    = r_sp;
                        w_mdr_in = r_data[2*WORD_LENGTH-1:WORD_LENGTH];
                    end
                    OP_RET:  w_mar = r_sp + ONE;
                    default: w_mar = '0;
                endcase
            end
            S_A2: begin
                w_mem = 1'b1;
                w_rw  = w_is_read;
                case (r_op)
                    OP_CALL: begin
                        w_mar    = r_sp - ONE;
                        w_mdr_in = r_data[WORD_LENGTH-1:0];
                    end
                    OP_RET:  w_mar = r_sp + TWO;
                    default: w_mar = '0;
                endcase
            end
            default: ;
        endcase
    end

    // Stack pointer after the current op; wraps modulo the address space.
    always_comb begin
        w_sp_next = r_sp;
        case (r_op)
            OP_PUSH: w_sp_next = r_sp - ONE;
            OP_POP:  w_sp_next = r_sp + ONE;
            OP_CALL: w_sp_next = r_sp - TWO;
            OP_RET:  w_sp_next = r_sp + TWO;
            default: w_sp_next = r_sp;
        endcase
    end

    // Access sequencer: IDLE -> A1 -> (A2 for two-word ops) -> IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) r_state <= S_A1;
                S_A1:    r_state <= w_two_word ? S_A2 : S_IDLE;
                S_A2:    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Capture the request on the accepting edge; held for the whole operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op   <= OP_NOP;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_op   <= bus.req_op;
            r_addr <= bus.req_addr;
            r_data <= bus.req_data;
        end
    end

    // Single SP update per op, only once its last access has completed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp <= SP_INIT;
        end else if (w_last) begin
            r_sp <= w_sp_next;
        end
    end

    // Response path. RET stages its low word so rsp_data changes only once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_ret_lo    <= '0;
        end else begin
            r_rsp_valid <= w_last;
            if ((r_state == S_A1) && ((r_op == OP_LDD) || (r_op == OP_POP))) begin
                r_rsp_data <= {{WORD_LENGTH{1'b0}}, bus.MDR_out};
            end
            if ((r_state == S_A1) && (r_op == OP_RET)) begin
                r_ret_lo <= bus.MDR_out;
            end
            if ((r_state == S_A2) && (r_op == OP_RET)) begin
                r_rsp_data <= {bus.MDR_out, r_ret_lo};
            end
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.sp        = r_sp;
    assign bus.MAR       = w_mar;
    assign bus.MDR_in    = w_mdr_in;
    assign bus.mem       = w_mem;
    assign bus.rw        = w_rw;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a behavioural data memory.
module tb_mem_stage_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic [15:0] dmem [0:4095];

    mem_stage_ctrl_if #(.WORD_LENGTH(16), .ADDRESS_SPACE(12)) bus ();

    mem_stage_ctrl #(.WORD_LENGTH(16), .ADDRESS_SPACE(12), .SP_RESET(4095)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write commits at the closing edge.
    assign bus.MDR_out = dmem[bus.MAR];
    always @(posedge clk) begin
        if (bus.mem && !bus.rw) dmem[bus.MAR] <= bus.MDR_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op, check every access cycle, the response cycle and the pulse end.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [11:0] addr,
                         input logic [31:0] data, input int n, input logic exp_rw,
                         input logic [11:0] m1, input logic [11:0] m2,
                         input logic [15:0] wd1, input logic [15:0] wd2,
                         input logic [31:0] exp_rsp, input logic [11:0] exp_sp);
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_data  = data;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        check({tag, "_a1_mem"}, 32'(bus.mem), 32'd1);
        check({tag, "_a1_rw"}, 32'(bus.rw), 32'(exp_rw));
        check({tag, "_a1_mar"}, 32'(bus.MAR), 32'(m1));
        if (!exp_rw) check({tag, "_a1_wd"}, 32'(bus.MDR_in), 32'(wd1));
        check({tag, "_a1_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_a1_rspv"}, 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        if (n == 2) begin
            check({tag, "_a2_mem"}, 32'(bus.mem), 32'd1);
            check({tag, "_a2_rw"}, 32'(bus.rw), 32'(exp_rw));
            check({tag, "_a2_mar"}, 32'(bus.MAR), 32'(m2));
            if (!exp_rw) check({tag, "_a2_wd"}, 32'(bus.MDR_in), 32'(wd2));
            check({tag, "_a2_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_a2_rspv"}, 32'(bus.rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        check({tag, "_rspv"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_mem_done"}, 32'(bus.mem), 32'd0);
        check({tag, "_rsp"}, bus.rsp_data, exp_rsp);
        check({tag, "_sp"}, 32'(bus.sp), 32'(exp_sp));
        @(posedge clk);
        #1;
        check({tag, "_rspv_end"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout no_finish got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int cnt_v;
        int cnt_b;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 4096; i++) dmem[i] = 16'h0;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        reset = 1'b1;
        #3;
        check("rst_sp", 32'(bus.sp), 32'hFFF);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_mem", 32'(bus.mem), 32'd0);
        check("rst_rspv", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp", bus.rsp_data, 32'd0);
        check("rst_mar", 32'(bus.MAR), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        //      tag     op    addr    data           n rw m1      m2      wd1      wd2      rsp            sp
        do_op("std",   3'd2, 12'd10, 32'd100,       1, 0, 12'd10, 12'd0,  16'd100, 16'd0,   32'd0,         12'hFFF);
        do_op("ldd",   3'd1, 12'd10, 32'd0,         1, 1, 12'd10, 12'd0,  16'd0,   16'd0,   32'd100,       12'hFFF);
        do_op("push1", 3'd3, 12'd0,  32'd200,       1, 0, 12'hFFF, 12'd0, 16'd200, 16'd0,   32'd100,       12'hFFE);
        do_op("push2", 3'd3, 12'd0,  32'd300,       1, 0, 12'hFFE, 12'd0, 16'd300, 16'd0,   32'd100,       12'hFFD);
        do_op("pop1",  3'd4, 12'd0,  32'd0,         1, 1, 12'hFFE, 12'd0, 16'd0,   16'd0,   32'd300,       12'hFFE);
        do_op("pop2",  3'd4, 12'd0,  32'd0,         1, 1, 12'hFFF, 12'd0, 16'd0,   16'd0,   32'd200,       12'hFFF);
        do_op("call",  3'd5, 12'd0,  32'h0001_2345, 2, 0, 12'hFFF, 12'hFFE, 16'h0001, 16'h2345, 32'd200,   12'hFFD);
        check("call_mem_hi", 32'(dmem[12'hFFF]), 32'h0001);
        check("call_mem_lo", 32'(dmem[12'hFFE]), 32'h2345);
        do_op("ret",   3'd6, 12'd0,  32'd0,         2, 1, 12'hFFE, 12'hFFF, 16'd0, 16'd0,   32'h0001_2345, 12'hFFF);
        do_op("popwrap",  3'd4, 12'd0, 32'd0,       1, 1, 12'h000, 12'd0, 16'd0,   16'd0,   32'd0,         12'h000);
        do_op("pushwrap", 3'd3, 12'd0, 32'h55,      1, 0, 12'h000, 12'd0, 16'h55,  16'd0,   32'd0,         12'hFFF);

        // NOP and reserved op must be ignored.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd0;
        @(posedge clk);
        #1;
        check("nop_busy", 32'(bus.busy), 32'd0);
        bus.req_op = 3'd7;
        @(posedge clk);
        #1;
        check("op7_busy", 32'(bus.busy), 32'd0);
        check("op7_mem", 32'(bus.mem), 32'd0);
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        @(posedge clk);
        #1;
        check("op7_rspv", 32'(bus.rsp_valid), 32'd0);
        check("op7_sp", 32'(bus.sp), 32'hFFF);

        // Reset during A2 of a CALL: high word stays, no response, SP untouched.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd5;
        bus.req_data  = 32'hBEEF_1234;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        @(posedge clk);
        #1;
        check("abort_a2_mem", 32'(bus.mem), 32'd1);
        check("abort_a2_mar", 32'(bus.MAR), 32'hFFE);
        reset = 1'b1;
        #1;
        check("abort_mem", 32'(bus.mem), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_sp", 32'(bus.sp), 32'hFFF);
        check("abort_rspv", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_rspv_after", 32'(bus.rsp_valid), 32'd0);
        check("abort_lo_untouched", 32'(dmem[12'hFFE]), 32'h2345);
        do_op("ldd_hi", 3'd1, 12'hFFF, 32'd0,      1, 1, 12'hFFF, 12'd0, 16'd0,   16'd0,   32'h0000_BEEF, 12'hFFF);

        // Reset mid-cycle after a PUSH restores SP and clears rsp_data.
        do_op("push7", 3'd3, 12'd0,  32'd7,         1, 0, 12'hFFF, 12'd0, 16'd7,   16'd0,   32'h0000_BEEF, 12'hFFE);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst2_sp", 32'(bus.sp), 32'hFFF);
        check("rst2_rsp", bus.rsp_data, 32'd0);
        check("rst2_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Held LDD request: one op every two cycles, accepted while rsp_valid is high.
        cnt_v = 0;
        cnt_b = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd1;
        bus.req_addr  = 12'd10;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            cnt_v += int'(bus.rsp_valid);
            cnt_b += int'(bus.busy);
            if (k == 5) begin
                bus.req_valid = 1'b0;
                bus.req_op    = 3'd0;
            end
        end
        check("b2b_rsp_pulses", 32'(cnt_v), 32'd3);
        check("b2b_busy_cycles", 32'(cnt_b), 32'd3);
        check("b2b_rsp", bus.rsp_data, 32'd100);
        @(posedge clk);
        #1;
        check("b2b_idle", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
